// File: rtl/rf_sched_pkg.sv
// ============================================================================
// Module : rf_sched_pkg
// Brief  : Shared widths, register-zero constant and LLU result buffer entry.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_sched_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] rd;
        logic [DEF_DATA_W-1:0] data;
    } fifo_entry_t;

    function automatic logic is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_write_port_scheduler_if.sv
// ============================================================================
// Module : rf_write_port_scheduler_if
// Brief  : WB, LLU, issue, decode and register-file write port signal bundle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rf_write_port_scheduler_if #(
    parameter int ADDR_W = rf_sched_pkg::DEF_ADDR_W,
    parameter int DATA_W = rf_sched_pkg::DEF_DATA_W
);

    logic              wb_we;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              llu_valid;
    logic              llu_ready;
    logic [ADDR_W-1:0] llu_rd;
    logic [DATA_W-1:0] llu_data;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_rd;
    logic              iss_ready;
    logic [ADDR_W-1:0] dec_rs1;
    logic [ADDR_W-1:0] dec_rs2;
    logic [ADDR_W-1:0] dec_rd;
    logic              dec_we;
    logic              dec_stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              wb_hold;

    modport master (
        output wb_we, wb_rd, wb_data,
        output llu_valid, llu_rd, llu_data,
        input  llu_ready,
        output iss_valid, iss_rd,
        input  iss_ready,
        output dec_rs1, dec_rs2, dec_rd, dec_we,
        input  dec_stall,
        input  rf_we, rf_waddr, rf_wdata,
        input  wb_hold
    );

    modport slave (
        input  wb_we, wb_rd, wb_data,
        input  llu_valid, llu_rd, llu_data,
        output llu_ready,
        input  iss_valid, iss_rd,
        output iss_ready,
        input  dec_rs1, dec_rs2, dec_rd, dec_we,
        output dec_stall,
        output rf_we, rf_waddr, rf_wdata,
        output wb_hold
    );

endinterface

`default_nettype wire

// File: rtl/rf_sync_fifo.sv
// ============================================================================
// Module : rf_sync_fifo
// Brief  : Power-of-two depth synchronous FIFO with show-ahead head output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_count = DEPTH[c_ptr_w:0];

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full    = (r_count == c_full_count);
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/rf_write_port_scheduler.sv
// ============================================================================
// Module : rf_write_port_scheduler
// Brief  : Arbitrates the register-file write port between WB and the LLU,
//          buffers LLU results and tracks busy LLU destinations for decode.
//          Optional starvation guard: define RF_SCHED_STARVE_GUARD_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_write_port_scheduler
    import rf_sched_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    rf_write_port_scheduler_if.slave  bus
);

    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2 || STARVE_LIMIT < 1 ||
        ADDR_W != DEF_ADDR_W || DATA_W != DEF_DATA_W) begin : g_param_check
        $error("rf_write_port_scheduler: unsupported parameter set");
    end

    fifo_entry_t             w_push_entry;
    fifo_entry_t             w_head;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_wb_active;
    logic                    w_grant_fifo;
    logic                    w_force;
    logic                    w_iss_ready;
    logic                    w_issue_set;
    logic                    w_hazard;
    logic [(1<<ADDR_W)-1:0]  r_busy;

    assign w_push_entry = {bus.llu_rd, bus.llu_data};

    rf_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_wb_active  = bus.wb_we && (bus.wb_rd != REG_ZERO);
    assign w_grant_fifo = !w_fifo_empty && (!w_wb_active || w_force);
    assign w_pop        = w_grant_fifo;

    // Writes to x0 never reach the buffer, so a granted head is never rd=0.
    assign bus.rf_we    = w_wb_active || !w_fifo_empty;
    assign bus.rf_waddr = w_grant_fifo ? w_head.rd   : bus.wb_rd;
    assign bus.rf_wdata = w_grant_fifo ? w_head.data : bus.wb_data;

    assign bus.llu_ready = !w_fifo_full;
    assign w_push        = bus.llu_valid && !w_fifo_full && (bus.llu_rd != REG_ZERO);

    assign w_iss_ready   = !((bus.iss_rd != REG_ZERO) && r_busy[bus.iss_rd]);
    assign bus.iss_ready = w_iss_ready;
    assign w_issue_set   = bus.iss_valid && w_iss_ready && (bus.iss_rd != REG_ZERO);

    assign w_hazard = ((bus.dec_rs1 != REG_ZERO) && r_busy[bus.dec_rs1]) ||
                      ((bus.dec_rs2 != REG_ZERO) && r_busy[bus.dec_rs2]) ||
                      (bus.dec_we && (bus.dec_rd != REG_ZERO) && r_busy[bus.dec_rd]) ||
                      (bus.iss_valid && !w_iss_ready);

    assign bus.dec_stall = w_hazard || w_force;
    assign bus.wb_hold   = w_force;

    // The issue path refuses busy destinations, so set and clear never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            if (w_pop) begin
                r_busy[w_head.rd] <= 1'b0;
            end
            if (w_issue_set) begin
                r_busy[bus.iss_rd] <= 1'b1;
            end
        end
    end

`ifdef RF_SCHED_STARVE_GUARD_EN
    localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

    logic [c_starve_w-1:0] r_starve_cnt;

    // Counts cycles in which WB has shut out a waiting LLU result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_pop || w_fifo_empty) begin
            r_starve_cnt <= '0;
        end else if (w_wb_active && (r_starve_cnt != c_starve_max)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_force = !w_fifo_empty && (r_starve_cnt == c_starve_max);
`else
    assign w_force = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_write_port_scheduler.sv
// ============================================================================
// Module : tb_rf_write_port_scheduler
// Brief  : Directed vector table plus hand sequences for rf_write_port_scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_write_port_scheduler;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    rf_write_port_scheduler_if bus ();

    rf_write_port_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        llu_valid;
        logic [4:0]  llu_rd;
        logic [31:0] llu_data;
        logic        iss_valid;
        logic [4:0]  iss_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        dec_we;
        logic        e_rf_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_llu_ready;
        logic        e_iss_ready;
        logic        e_stall;
    } vec_t;

    localparam int c_nvec = 18;
    vec_t vecs [c_nvec];

    function automatic vec_t mk(
        input logic wb_we, input logic [4:0] wb_rd, input logic [31:0] wb_data,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
        input logic iv, input logic [4:0] ird,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic dwe,
        input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_data,
        input logic e_lr, input logic e_ir, input logic e_st);
        vec_t v;
        v.wb_we = wb_we;   v.wb_rd = wb_rd;     v.wb_data = wb_data;
        v.llu_valid = lv;  v.llu_rd = lrd;      v.llu_data = ldata;
        v.iss_valid = iv;  v.iss_rd = ird;
        v.rs1 = rs1;       v.rs2 = rs2;         v.rd = rd;        v.dec_we = dwe;
        v.e_rf_we = e_we;  v.e_waddr = e_addr;  v.e_wdata = e_data;
        v.e_llu_ready = e_lr; v.e_iss_ready = e_ir; v.e_stall = e_st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.wb_we = 1'b0;     bus.wb_rd = '0;    bus.wb_data = '0;
        bus.llu_valid = 1'b0; bus.llu_rd = '0;   bus.llu_data = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.dec_rs1 = '0;     bus.dec_rs2 = '0;  bus.dec_rd = '0;  bus.dec_we = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        bus.wb_we = v.wb_we;         bus.wb_rd = v.wb_rd;     bus.wb_data = v.wb_data;
        bus.llu_valid = v.llu_valid; bus.llu_rd = v.llu_rd;   bus.llu_data = v.llu_data;
        bus.iss_valid = v.iss_valid; bus.iss_rd = v.iss_rd;
        bus.dec_rs1 = v.rs1;         bus.dec_rs2 = v.rs2;     bus.dec_rd = v.rd;
        bus.dec_we = v.dec_we;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle();

        //            wb            llu              iss    rs1 rs2 rd dwe  rf_we/addr/data   lr ir st
        vecs[0]  = mk(0, 2, 'h11,   0, 0, 0,         0, 0,  0, 0, 0, 0,   0, 2, 'h11,       1, 1, 0);
        vecs[1]  = mk(1, 3, 'h33,   0, 0, 0,         0, 0,  0, 0, 0, 0,   1, 3, 'h33,       1, 1, 0);
        vecs[2]  = mk(1, 0, 'h44,   0, 0, 0,         0, 0,  0, 0, 0, 0,   0, 0, 'h44,       1, 1, 0);
        vecs[3]  = mk(0, 0, 0,      0, 0, 0,         1, 5,  0, 0, 0, 0,   0, 0, 0,          1, 1, 0);
        vecs[4]  = mk(0, 0, 0,      1, 5, 'hDEAD,    0, 0,  5, 0, 0, 0,   0, 0, 0,          1, 1, 1);
        vecs[5]  = mk(0, 0, 0,      0, 0, 0,         0, 0,  5, 0, 0, 0,   1, 5, 'hDEAD,     1, 1, 1);
        vecs[6]  = mk(0, 0, 0,      0, 0, 0,         0, 0,  5, 0, 0, 0,   0, 0, 0,          1, 1, 0);
        vecs[7]  = mk(0, 0, 0,      0, 0, 0,         1, 7,  0, 0, 0, 0,   0, 0, 0,          1, 1, 0);
        vecs[8]  = mk(0, 0, 0,      0, 0, 0,         0, 0,  0, 7, 0, 0,   0, 0, 0,          1, 1, 1);
        vecs[9]  = mk(0, 0, 0,      0, 0, 0,         1, 7,  0, 0, 0, 0,   0, 0, 0,          1, 0, 1);
        vecs[10] = mk(0, 0, 0,      0, 0, 0,         0, 0,  0, 0, 7, 1,   0, 0, 0,          1, 1, 1);
        vecs[11] = mk(0, 0, 0,      0, 0, 0,         0, 0,  0, 0, 7, 0,   0, 0, 0,          1, 1, 0);
        vecs[12] = mk(0, 0, 0,      0, 0, 0,         1, 0,  0, 0, 0, 0,   0, 0, 0,          1, 1, 0);
        vecs[13] = mk(0, 0, 0,      1, 7, 'h77,      0, 0,  0, 7, 0, 0,   0, 0, 0,          1, 1, 1);
        vecs[14] = mk(0, 0, 0,      0, 0, 0,         0, 0,  0, 7, 0, 0,   1, 7, 'h77,       1, 1, 1);
        vecs[15] = mk(0, 0, 0,      0, 0, 0,         0, 0,  0, 7, 0, 0,   0, 0, 0,          1, 1, 0);
        vecs[16] = mk(0, 0, 0,      1, 0, 'h99,      0, 0,  0, 0, 0, 0,   0, 0, 0,          1, 1, 0);
        vecs[17] = mk(0, 0, 0,      0, 0, 0,         0, 0,  0, 0, 0, 0,   0, 0, 0,          1, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < c_nvec; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d rf_we", i),     bus.rf_we,     vecs[i].e_rf_we);
            chk($sformatf("v%0d rf_waddr", i),  bus.rf_waddr,  vecs[i].e_waddr);
            chk($sformatf("v%0d rf_wdata", i),  bus.rf_wdata,  vecs[i].e_wdata);
            chk($sformatf("v%0d llu_ready", i), bus.llu_ready, vecs[i].e_llu_ready);
            chk($sformatf("v%0d iss_ready", i), bus.iss_ready, vecs[i].e_iss_ready);
            chk($sformatf("v%0d dec_stall", i), bus.dec_stall, vecs[i].e_stall);
            chk($sformatf("v%0d wb_hold", i),   bus.wb_hold,   1'b0);
            tick();
        end

        // WB owns the port while two LLU results fill the buffer
        idle();
        bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h3333;
        bus.llu_valid = 1'b1; bus.llu_rd = 5'd10; bus.llu_data = 32'hA0;
        @(negedge clk);
        chk("A0 llu_ready", bus.llu_ready, 1'b1);
        chk("A0 rf_waddr", bus.rf_waddr, 5'd3);
        tick();
        bus.llu_rd = 5'd11; bus.llu_data = 32'hB0;
        @(negedge clk);
        chk("A1 llu_ready", bus.llu_ready, 1'b1);
        chk("A1 rf_waddr", bus.rf_waddr, 5'd3);
        tick();
        bus.llu_rd = 5'd12; bus.llu_data = 32'hC0;
        @(negedge clk);
        chk("A2 llu_ready", bus.llu_ready, 1'b0);
        chk("A2 rf_waddr", bus.rf_waddr, 5'd3);
        chk("A2 rf_wdata", bus.rf_wdata, 32'h3333);
        tick();
        bus.llu_valid = 1'b0;
        @(negedge clk);
        chk("A3 llu_ready", bus.llu_ready, 1'b0);
        chk("A3 rf_waddr", bus.rf_waddr, 5'd3);
        tick();
        bus.wb_we = 1'b0;
        @(negedge clk);
        chk("A4 rf_we", bus.rf_we, 1'b1);
        chk("A4 rf_waddr", bus.rf_waddr, 5'd10);
        chk("A4 rf_wdata", bus.rf_wdata, 32'hA0);
        chk("A4 llu_ready", bus.llu_ready, 1'b0);
        tick();
        @(negedge clk);
        chk("A5 rf_waddr", bus.rf_waddr, 5'd11);
        chk("A5 rf_wdata", bus.rf_wdata, 32'hB0);
        chk("A5 llu_ready", bus.llu_ready, 1'b1);
        tick();
        @(negedge clk);
        chk("A6 rf_we", bus.rf_we, 1'b0);
        tick();

        // Continuous WB with one buffered LLU result
        idle();
        bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h3333;
        bus.llu_valid = 1'b1; bus.llu_rd = 5'd13; bus.llu_data = 32'hD0;
        tick();
        bus.llu_valid = 1'b0;
`ifdef RF_SCHED_STARVE_GUARD_EN
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("S%0d wb_hold", c), bus.wb_hold, 1'b0);
            chk($sformatf("S%0d rf_waddr", c), bus.rf_waddr, 5'd3);
            tick();
        end
        @(negedge clk);
        chk("S5 wb_hold", bus.wb_hold, 1'b1);
        chk("S5 dec_stall", bus.dec_stall, 1'b1);
        chk("S5 rf_waddr", bus.rf_waddr, 5'd13);
        chk("S5 rf_wdata", bus.rf_wdata, 32'hD0);
        tick();
        @(negedge clk);
        chk("S6 wb_hold", bus.wb_hold, 1'b0);
        chk("S6 rf_waddr", bus.rf_waddr, 5'd3);
        tick();
        bus.wb_we = 1'b0;
        @(negedge clk);
        chk("S7 rf_we", bus.rf_we, 1'b0);
        tick();
`else
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("W%0d wb_hold", c), bus.wb_hold, 1'b0);
            chk($sformatf("W%0d rf_waddr", c), bus.rf_waddr, 5'd3);
            tick();
        end
        bus.wb_we = 1'b0;
        @(negedge clk);
        chk("W9 rf_waddr", bus.rf_waddr, 5'd13);
        chk("W9 rf_wdata", bus.rf_wdata, 32'hD0);
        tick();
        @(negedge clk);
        chk("W10 rf_we", bus.rf_we, 1'b0);
        tick();
`endif

        // Reset with a full buffer and busy[4]
        idle();
        bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h3333;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
        bus.llu_valid = 1'b1; bus.llu_rd = 5'd20; bus.llu_data = 32'h20;
        tick();
        bus.iss_valid = 1'b0;
        bus.llu_rd = 5'd21; bus.llu_data = 32'h21;
        tick();
        bus.llu_valid = 1'b0; bus.wb_we = 1'b0;
        bus.dec_rs1 = 5'd4; bus.iss_rd = 5'd4;
        @(negedge clk);
        chk("R pre dec_stall", bus.dec_stall, 1'b1);
        chk("R pre llu_ready", bus.llu_ready, 1'b0);
        chk("R pre iss_ready", bus.iss_ready, 1'b0);
        chk("R pre rf_we", bus.rf_we, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("R rf_we", bus.rf_we, 1'b0);
        chk("R llu_ready", bus.llu_ready, 1'b1);
        chk("R iss_ready", bus.iss_ready, 1'b1);
        chk("R dec_stall", bus.dec_stall, 1'b0);
        chk("R wb_hold", bus.wb_hold, 1'b0);
        tick();
        reset = 1'b0;
        idle();
        bus.llu_valid = 1'b1; bus.llu_rd = 5'd4; bus.llu_data = 32'h44;
        @(negedge clk);
        chk("R1 llu_ready", bus.llu_ready, 1'b1);
        chk("R1 rf_we", bus.rf_we, 1'b0);
        tick();
        bus.llu_valid = 1'b0;
        @(negedge clk);
        chk("R2 rf_we", bus.rf_we, 1'b1);
        chk("R2 rf_waddr", bus.rf_waddr, 5'd4);
        chk("R2 rf_wdata", bus.rf_wdata, 32'h44);
        tick();
        @(negedge clk);
        chk("R3 rf_we", bus.rf_we, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
